unpack_s3: RTL and testbench
============================

// Module: unpack_s3
// PURPOSE
// Unpacks a byte-packed ternary polynomial back into 2-bit trits, the inverse of pack_s3.
// Each input byte v encodes 5 trits: v = t0 + 3*t1 + 9*t2 + 27*t3 + 81*t4.
// The block sits on the NTRU-HRSS decapsulation path, where it decodes received S3 polynomials.
// It is iterative: one byte is processed per 7 clocks, and trits are produced by exact division by 3.
// PARAMETERS
// N_BYTES   140  packed bytes; input width is 8*N_BYTES, output width is 10*N_BYTES (5*N_BYTES trits)
// PORTS
// clk    in   1             clock; all state updates on posedge
// rst    in   1             reset, synchronous, active-high
// start  in   1             begin unpacking; sampled only in IDLE
// a      in   8*N_BYTES     packed bytes; byte i = a[8i+8:8i+1]
// out    out  10*N_BYTES    trits; trit k = out[2k+2:2k+1], unsigned value 0..2
// busy   out  1             high while a conversion is in progress
// done   out  1             one-cycle pulse; out is valid from this cycle on
// err    out  1             sticky; set if any processed byte > 242
// BEHAVIOUR
// - Reset (rst=1 at posedge, has priority over everything): state=IDLE, out=0, busy=0, done=0, err=0,
//   byte counter=0. rst asserted mid-conversion aborts it; no done pulse follows.
// - States:
//   - IDLE: when start=1, capture a into the shift register, clear err, clear the counter, go to LOAD.
//   - LOAD (1 cycle): v <= shreg[8:1]; go to DIGIT with digit index d=0.
//   - DIGIT (5 cycles, d=0..4): trit_d = v - 3*floor(v/3); v <= floor(v/3).
//     - Shift trit_d into a 10-bit staging register at its position d.
//     - For d=4, use (v mod 3). A byte v>242 thus decodes to digits of v with the top digit reduced mod 3.
//     - floor(v/3) is exact for 0..255 ((v*171)>>9 is acceptable).
//   - SHIFT (1 cycle): out <= {staging, out[10*N_BYTES:11]}, i.e. shift right by 10 and insert at top.
//     - shreg <= shreg >> 8.
//     - If any trit came from a byte >242, set err.
//     - If counter == N_BYTES-1, go to DONE; else counter++ and go to LOAD.
//   - DONE (1 cycle): done=1, busy=0; go to IDLE.
// - Byte ordering: after N_BYTES shifts, byte 0's trits sit in out[10:1] and byte N_BYTES-1's trits at the top.
//   This matches pack_s3 ordering exactly.
// - Timing:
//   - busy=1 in LOAD/DIGIT/SHIFT.
//   - If start is sampled at posedge T0, done=1 during the cycle after posedge T0+7*N_BYTES+1 (981 cycles for 140).
// - Handshake:
//   - start is ignored while busy or in DONE; no queuing.
//   - a may change freely after the start edge.
//   - out holds its value in IDLE until the next start capture.
//   - out is intermediate (partially shifted) while busy and must not be consumed.
// - err is valid with done and holds until the next accepted start or rst.
// TESTING
// 1. a=0, start -> after 981 cycles, done pulses once; out=0, err=0; busy high for exactly 980 cycles.
// 2. byte0=8'h2E (46), others 0 -> out[10:1]=10'b00_01_10_00_01 (t0=1,t1=0,t2=2,t3=1,t4=0); err=0.
// 3. All bytes 242 -> every trit =2 (out all 2'b10); err=0. byte5=243 -> trits 25..29 = 0, err=1 at done.
// 4. Random valid trits -> pack_s3 -> unpack_s3: out equals original trits for 1000 random vectors.
// 5. rst asserted at cycle 500 of a run -> next cycle out=0, busy=0, err=0; no done pulse; new start completes normally.
// 6. start held high through a run, and pulsed mid-run -> exactly one done per accepted start.
//    A start present in the cycle after done is accepted.

Source files
------------

// File: rtl/unpack_s3_if.sv
// Handshake and data bundle between a controller and the unpack_s3 ternary decoder.
// The controller drives start and the packed bytes; the decoder returns trits and status.
interface unpack_s3_if #(
  parameter int N_BYTES = 140
);
  logic                    start;
  logic [8*N_BYTES-1:0]    a;
  logic [10*N_BYTES-1:0]   out;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output start, a,
    input  out, busy, done, err
  );

  modport slave (
    input  start, a,
    output out, busy, done, err
  );
endinterface

// File: rtl/unpack_s3.sv
// Iterative S3 unpacker: decodes one packed byte into five 2-bit trits every 7 clocks
// by repeated exact division by 3, shifting each decoded byte into the top of the output.
module unpack_s3 #(
  parameter int N_BYTES = 140
) (
  input  logic       clk,
  input  logic       rst,
  unpack_s3_if.slave bus
);
  localparam int AW = 8 * N_BYTES;
  localparam int OW = 10 * N_BYTES;
  localparam int CW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(N_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIGIT,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   shreg_q, shreg_d;
  logic [OW-1:0]   out_q,   out_d;
  logic [7:0]      v_q,     v_d;
  logic [2:0]      d_q,     d_d;
  logic [9:0]      stage_q, stage_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            bad_q,   bad_d;
  logic            busy_q,  busy_d;
  logic            done_q,  done_d;
  logic            err_q,   err_d;

  // floor(v/3) as (v*171)>>9, exact for every 8-bit v; remainder is the trit.
  logic [15:0] prod;
  logic [7:0]  quot;
  logic [7:0]  quot3;
  logic [7:0]  rem;
  logic [1:0]  trit;
  logic [14:0] unused_bits;

  assign prod        = 16'(v_q) * 16'd171;
  assign quot        = {1'b0, prod[15:9]};
  assign quot3       = quot + {quot[6:0], 1'b0};
  assign rem         = v_q - quot3;
  assign trit        = rem[1:0];
  assign unused_bits = {prod[8:0], rem[7:2]};

  // Each staging slot is cleared on LOAD and written once, when the digit index reaches it.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_stage
      always_comb begin
        stage_d[2*gi +: 2] = stage_q[2*gi +: 2];
        if (state_q == S_LOAD) begin
          stage_d[2*gi +: 2] = 2'b00;
        end else if (state_q == S_DIGIT && d_q == 3'(gi)) begin
          stage_d[2*gi +: 2] = trit;
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    v_d     = v_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.a;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end

      S_LOAD: begin
        v_d     = shreg_q[7:0];
        bad_d   = (shreg_q[7:0] > 8'd242);
        d_d     = 3'd0;
        state_d = S_DIGIT;
        busy_d  = 1'b1;
      end

      S_DIGIT: begin
        v_d    = quot;
        busy_d = 1'b1;
        if (d_q == 3'd4) begin
          state_d = S_SHIFT;
        end else begin
          d_d = d_q + 3'd1;
        end
      end

      S_SHIFT: begin
        // Newest byte enters at the top, so byte 0 ends up in the lowest 10 bits.
        out_d   = {stage_q, out_q[OW-1:10]};
        shreg_d = shreg_q >> 8;
        if (bad_q) begin
          err_d = 1'b1;
        end
        if (cnt_q == LAST_BYTE) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      out_q   <= '0;
      v_q     <= '0;
      d_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      v_q     <= v_d;
      d_q     <= d_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_unpack_s3.sv
// Self-checking bench for unpack_s3: table vectors, randomized pack/unpack round trips,
// and hand-written sequences for start handling and mid-run reset.
module tb_unpack_s3;
  localparam int N       = 140;
  localparam int AW      = 8 * N;
  localparam int OW      = 10 * N;
  localparam int LAT     = 7 * N + 1;
  localparam int BUSY_N  = 7 * N;

  logic clk = 1'b0;
  logic rst;

  unpack_s3_if #(.N_BYTES(N)) bus ();
  unpack_s3 #(.N_BYTES(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] fill;
    int         idx;
    logic [7:0] val;
    logic [9:0] exp_fill;
    logic [9:0] exp_spec;
    logic       exp_err;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    tests++;
    if (act !== exp) begin
      int k;
      k = 0;
      while (k < 5*N && act[2*k +: 2] === exp[2*k +: 2]) k++;
      fails++;
      $display("FAIL %s: trit %0d got %0d, want %0d", nm, k, act[2*k +: 2], exp[2*k +: 2]);
    end
  endtask

  // Digit decomposition straight from the packing rule; the fifth digit is whatever is left, mod 3.
  function automatic logic [9:0] dec_byte(input int v);
    logic [9:0] r;
    int x;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[2*d +: 2] = 2'(x % 3);
      x = x / 3;
    end
    r[9:8] = 2'(x % 3);
    return r;
  endfunction

  // Starts a conversion and returns the cycle count to done and how many cycles busy was high.
  task automatic run_conv(input logic [AW-1:0] av, input int pulse_at,
                          output int lat, output int busy_cnt);
    int k;
    @(negedge clk);
    bus.a     = av;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = ~av;
    k = 0; busy_cnt = 0; lat = -1;
    while (k < 1200) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = k;
        break;
      end
      bus.start = (k == pulse_at);
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
  endtask

  task automatic quiet_check(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk(nm, seen, 0);
  endtask

  task automatic build(input vec_t v, output logic [AW-1:0] av, output logic [OW-1:0] ev);
    for (int i = 0; i < N; i++) begin
      av[8*i +: 8]  = (i == v.idx) ? v.val : v.fill;
      ev[10*i +: 10] = (i == v.idx) ? v.exp_spec : v.exp_fill;
    end
  endtask

  initial begin
    logic [AW-1:0] av, av2;
    logic [OW-1:0] ev, ev2;
    int lat, bc, k, nd, d1, d2;
    logic exp_err;
    int trits[5*N];

    vt[0] = '{8'd0,   0,   8'd0,   10'd0,           10'd0,           1'b0};
    vt[1] = '{8'd0,   0,   8'd46,  10'd0,           10'b0001100001,  1'b0};
    vt[2] = '{8'd242, 0,   8'd242, 10'b1010101010,  10'b1010101010,  1'b0};
    vt[3] = '{8'd242, 5,   8'd243, 10'b1010101010,  10'd0,           1'b1};
    vt[4] = '{8'd0,   139, 8'd1,   10'd0,           10'b0000000001,  1'b0};
    vt[5] = '{8'd255, 0,   8'd255, 10'b0000010100,  10'b0000010100,  1'b1};
    vt[6] = '{8'd121, 70,  8'd80,  10'b0101010101,  10'b0010101010,  1'b0};
    vt[7] = '{8'd0,   3,   8'd250, 10'd0,           10'b0000001001,  1'b1};

    rst = 1'b1; bus.start = 1'b0; bus.a = '0;
    repeat (3) @(negedge clk);
    chk_out("reset_out", bus.out, '0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_err", bus.err, 0);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      build(vt[t], av, ev);
      run_conv(av, -1, lat, bc);
      chk_out($sformatf("vec%0d_out", t), bus.out, ev);
      chk($sformatf("vec%0d_err", t), bus.err, vt[t].exp_err);
      chk($sformatf("vec%0d_latency", t), lat, LAT);
      chk($sformatf("vec%0d_busy_cycles", t), bc, BUSY_N);
      $display("[TB] vector %0d fill=%0d byte%0d=%0d latency=%0d", t, vt[t].fill, vt[t].idx, vt[t].val, lat);
    end
    quiet_check("done_single_pulse", 3);

    // Round trips: mostly packed random trits, occasionally a raw byte (possibly > 242).
    for (int r = 0; r < 20; r++) begin
      exp_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        int b;
        if ($urandom_range(7) == 0) begin
          logic [9:0] dt;
          b  = int'($urandom_range(255));
          dt = dec_byte(b);
          for (int d = 0; d < 5; d++) trits[5*i+d] = int'(dt[2*d +: 2]);
          if (b > 242) exp_err = 1'b1;
        end else begin
          b = 0;
          for (int d = 4; d >= 0; d--) begin
            trits[5*i+d] = int'($urandom_range(2));
          end
          for (int d = 4; d >= 0; d--) b = b * 3 + trits[5*i+d];
        end
        av[8*i +: 8] = 8'(b);
      end
      for (int k2 = 0; k2 < 5*N; k2++) ev[2*k2 +: 2] = 2'(trits[k2]);
      run_conv(av, -1, lat, bc);
      chk_out($sformatf("rand%0d_out", r), bus.out, ev);
      chk($sformatf("rand%0d_err", r), bus.err, exp_err);
      chk($sformatf("rand%0d_latency", r), lat, LAT);
      $display("[TB] random %0d err=%0d latency=%0d", r, exp_err, lat);
    end

    // Start pulses while busy and while in the DONE cycle must be ignored.
    build(vt[6], av, ev);
    run_conv(av, 300, lat, bc);
    chk_out("pulse_busy_out", bus.out, ev);
    chk("pulse_busy_latency", lat, LAT);
    quiet_check("pulse_busy_quiet", 5);
    $display("[TB] start pulse mid-run latency=%0d", lat);
    build(vt[1], av, ev);
    run_conv(av, LAT - 1, lat, bc);
    chk_out("pulse_done_out", bus.out, ev);
    chk("pulse_done_latency", lat, LAT);
    quiet_check("pulse_done_quiet", 5);
    $display("[TB] start pulse in done-state cycle latency=%0d", lat);

    // start held high: one done per accepted start, re-accepted in the done cycle.
    build(vt[6], av, ev);
    build(vt[2], av2, ev2);
    @(negedge clk);
    bus.a = av; bus.start = 1'b1;
    @(posedge clk);
    nd = 0; d1 = -1; d2 = -1;
    for (k = 0; k <= 2 * LAT + 1; k++) begin
      @(negedge clk);
      if (k == 1) bus.a = av2;
      if (bus.done) begin
        nd++;
        if (nd == 1) begin
          d1 = k;
          chk_out("hold_first_out", bus.out, ev);
        end else d2 = k;
      end
    end
    bus.start = 1'b0;
    chk("hold_done_count", nd, 2);
    chk("hold_first_done", d1, LAT);
    chk("hold_second_done", d2, 2 * LAT + 1);
    chk_out("hold_second_out", bus.out, ev2);
    quiet_check("hold_quiet", 5);
    $display("[TB] held start dones=%0d at %0d and %0d", nd, d1, d2);

    // Reset mid-run aborts with no done; a fresh start then completes.
    build(vt[5], av, ev);
    @(negedge clk);
    bus.a = av; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (k = 0; k < 500; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_out("abort_out", bus.out, '0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_done", bus.done, 0);
    quiet_check("abort_no_done", 1000);
    $display("[TB] reset at cycle 500 aborted the run");
    build(vt[3], av, ev);
    run_conv(av, -1, lat, bc);
    chk_out("after_abort_out", bus.out, ev);
    chk("after_abort_err", bus.err, 1);
    chk("after_abort_latency", lat, LAT);
    $display("[TB] run after reset latency=%0d", lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
